// File: rtl/cnn_upsampling_nn.sv
// Nearest-neighbour 2x upsampler: buffers one multi-channel frame, then streams
// each pixel out as a 2x2 block, channel-major and row-major.
module cnn_upsampling_nn #(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned IMAGE_WIDTH  = 16,
  parameter int unsigned IMAGE_HEIGHT = 16,
  parameter int unsigned CHANNEL_NUM  = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  valid_in,
  input  logic [DATA_WIDTH-1:0] pxl_in,
  output logic [DATA_WIDTH-1:0] pxl_out,
  output logic                  valid_out
);

  localparam int unsigned IMAGE_SIZE = IMAGE_WIDTH * IMAGE_HEIGHT;
  localparam int unsigned N_IN       = CHANNEL_NUM * IMAGE_SIZE;
  localparam int unsigned OW         = 2 * IMAGE_WIDTH;
  localparam int unsigned OH         = 2 * IMAGE_HEIGHT;
  localparam int unsigned AW         = (N_IN > 1) ? $clog2(N_IN) : 1;
  localparam int unsigned XW         = $clog2(OW);
  localparam int unsigned YW         = $clog2(OH);
  localparam int unsigned CW         = (CHANNEL_NUM > 1) ? $clog2(CHANNEL_NUM) : 1;

  typedef enum logic {LOAD, OUT} state_t;

  state_t          state, state_nxt;
  logic [AW-1:0]   wr_addr, wr_addr_nxt;
  logic [XW-1:0]   x, x_nxt;
  logic [YW-1:0]   y, y_nxt;
  logic [CW-1:0]   c, c_nxt;
  logic            wr_en_c, rd_en_c;
  logic [AW-1:0]   rd_addr_c;
  logic            rd_valid;
  logic [DATA_WIDTH-1:0] rd_data;
  logic [DATA_WIDTH-1:0] mem [N_IN];

  // Source pixel of the current output position: halve both output coordinates.
  assign rd_addr_c = AW'(c) * AW'(IMAGE_SIZE)
                   + AW'(y >> 1) * AW'(IMAGE_WIDTH)
                   + AW'(x >> 1);

  // Next-state and counter logic.
  always_comb begin
    state_nxt   = state;
    wr_addr_nxt = wr_addr;
    x_nxt       = x;
    y_nxt       = y;
    c_nxt       = c;
    wr_en_c     = 1'b0;
    rd_en_c     = 1'b0;
    case (state)
      LOAD: begin
        if (valid_in) begin
          wr_en_c = 1'b1;
          if (wr_addr == AW'(N_IN - 1)) begin
            wr_addr_nxt = '0;
            state_nxt   = OUT;
          end else begin
            wr_addr_nxt = wr_addr + AW'(1);
          end
        end
      end
      OUT: begin
        rd_en_c = 1'b1;
        if (x == XW'(OW - 1)) begin
          x_nxt = '0;
          if (y == YW'(OH - 1)) begin
            y_nxt = '0;
            if (c == CW'(CHANNEL_NUM - 1)) begin
              c_nxt     = '0;
              state_nxt = LOAD;
            end else begin
              c_nxt = c + CW'(1);
            end
          end else begin
            y_nxt = y + YW'(1);
          end
        end else begin
          x_nxt = x + XW'(1);
        end
      end
      default: state_nxt = LOAD;
    endcase
  end

  // State, counters and the two-stage output pipeline (read, then output register).
  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= LOAD;
      wr_addr   <= '0;
      x         <= '0;
      y         <= '0;
      c         <= '0;
      rd_valid  <= 1'b0;
      valid_out <= 1'b0;
      pxl_out   <= '0;
    end else begin
      state     <= state_nxt;
      wr_addr   <= wr_addr_nxt;
      x         <= x_nxt;
      y         <= y_nxt;
      c         <= c_nxt;
      rd_valid  <= rd_en_c;
      valid_out <= rd_valid;
      if (rd_valid) pxl_out <= rd_data;
    end
  end

  // Frame buffer: one write port, one synchronous read port, no reset.
  always_ff @(posedge clk) begin
    if (wr_en_c) mem[wr_addr] <= pxl_in;
    if (rd_en_c) rd_data <= mem[rd_addr_c];
  end

endmodule

// File: tb/tb_cnn_upsampling_nn.sv
// Directed bench for cnn_upsampling_nn with a queue scoreboard of expected outputs.
module tb_cnn_upsampling_nn;

  localparam int unsigned N_OUT = 4096;

  logic        clk = 1'b0;
  logic        reset;
  logic        valid_in;
  logic [31:0] pxl_in;
  logic [31:0] pxl_out;
  logic        valid_out;

  int          tests = 0;
  int          fails = 0;
  logic [31:0] exp_q [$];
  logic [31:0] got [N_OUT];
  int          run = 0;
  int          last_run = 0;
  int          junk_seen = 0;
  bit          mon_en = 1'b0;

  cnn_upsampling_nn dut (
    .clk      (clk),
    .reset    (reset),
    .valid_in (valid_in),
    .pxl_in   (pxl_in),
    .pxl_out  (pxl_out),
    .valid_out(valid_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Scoreboard monitor: every valid output pops one expected value.
  always @(negedge clk) begin
    if (!mon_en) begin
      run = 0;
    end else if (valid_out) begin
      if (pxl_out === 32'hDEADBEEF) junk_seen++;
      chk("output_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) chk("output_value", pxl_out, exp_q.pop_front());
      if (run < int'(N_OUT)) got[run] = pxl_out;
      run++;
    end else if (run != 0) begin
      last_run = run;
      run = 0;
    end
  end

  task automatic push_frame(input logic [31:0] base);
    for (int c = 0; c < 4; c++)
      for (int y = 0; y < 32; y++)
        for (int x = 0; x < 32; x++)
          exp_q.push_back(base + 32'(c * 256 + (y / 2) * 16 + x / 2));
  endtask

  // Feed one frame, then check the two-edge latency to the first output.
  task automatic send_frame(input logic [31:0] base, input bit stall, input bit junk);
    for (int i = 0; i < 1024; i++) begin
      @(posedge clk); #1;
      valid_in = 1'b1;
      pxl_in   = base + 32'(i);
      if (stall && (i % 7 == 6)) begin
        @(posedge clk); #1;
        valid_in = 1'b0;
        pxl_in   = '0;
        repeat (2) @(posedge clk);
      end
    end
    push_frame(base);
    @(posedge clk); #1;
    valid_in = junk;
    pxl_in   = junk ? 32'hDEADBEEF : 32'h0;
    chk("lat_edge0", 32'(valid_out), 32'd0);
    @(posedge clk); #1;
    chk("lat_edge1", 32'(valid_out), 32'd0);
    @(posedge clk); #1;
    chk("lat_edge2", 32'(valid_out), 32'd1);
    if (junk) begin
      for (int i = 0; i < 6000 && exp_q.size() > 8; i++) @(posedge clk);
      #1;
      valid_in = 1'b0;
      pxl_in   = '0;
    end
  endtask

  task automatic wait_drain(input string tag);
    bit done = 1'b0;
    for (int i = 0; i < 6000 && !done; i++) begin
      @(negedge clk); #1;
      if (exp_q.size() == 0 && !valid_out) done = 1'b1;
    end
    chk({tag, "_drained"}, 32'(done), 32'd1);
    chk({tag, "_burst_len"}, 32'(last_run), 32'(N_OUT));
    exp_q.delete();
  endtask

  initial begin
    reset    = 1'b0;
    valid_in = 1'b0;
    pxl_in   = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_valid_out", 32'(valid_out), 32'd0);
    chk("reset_pxl_out", pxl_out, 32'd0);
    reset  = 1'b1;
    mon_en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("idle_valid_out", 32'(valid_out), 32'd0);
    end

    // Ramp frame
    send_frame(32'h0, 1'b0, 1'b0);
    wait_drain("ramp");
    chk("ramp_o0", got[0], 32'h0);
    chk("ramp_o1", got[1], 32'h0);
    chk("ramp_o2", got[2], 32'h1);
    chk("ramp_o3", got[3], 32'h1);
    chk("ramp_o32", got[32], 32'h0);
    chk("ramp_o33", got[33], 32'h0);
    chk("ramp_o34", got[34], 32'h1);
    chk("ramp_o35", got[35], 32'h1);
    chk("ramp_o64", got[64], 32'h10);
    chk("ramp_o1024", got[1024], 32'h100);
    chk("ramp_o4095", got[4095], 32'h3FF);
    chk("pxl_hold", pxl_out, 32'h3FF);

    // Stalled input
    send_frame(32'h0, 1'b1, 1'b0);
    wait_drain("stall");

    // Input during OUT must be dropped
    send_frame(32'h0, 1'b0, 1'b1);
    wait_drain("junk");
    chk("junk_seen", 32'(junk_seen), 32'd0);

    // Second frame directly after: also proves the junk did not enter the buffer
    send_frame(32'hA000_0000, 1'b0, 1'b0);
    wait_drain("frame2");
    chk("frame2_o1", got[1], 32'hA000_0000);
    chk("frame2_o2", got[2], 32'hA000_0001);
    chk("frame2_o4095", got[4095], 32'hA000_03FF);

    // Reset mid-OUT
    send_frame(32'h0, 1'b0, 1'b0);
    begin
      bit reached = 1'b0;
      for (int i = 0; i < 6000 && !reached; i++) begin
        @(negedge clk); #1;
        if (run >= 100) reached = 1'b1;
      end
      chk("midout_reached_100", 32'(reached), 32'd1);
    end
    mon_en = 1'b0;
    reset  = 1'b0;
    @(posedge clk); #1;
    chk("midout_valid_out", 32'(valid_out), 32'd0);
    chk("midout_pxl_out", pxl_out, 32'd0);
    exp_q.delete();
    @(posedge clk); #1;
    reset  = 1'b1;
    mon_en = 1'b1;
    @(posedge clk); #1;
    chk("post_reset_idle", 32'(valid_out), 32'd0);
    send_frame(32'h5000_0000, 1'b0, 1'b0);
    wait_drain("after_reset");
    chk("after_reset_o0", got[0], 32'h5000_0000);
    chk("after_reset_o4095", got[4095], 32'h5000_03FF);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/cnn_upsampling_nn.md
Name: cnn_upsampling_nn

Overview:
Nearest-neighbour 2x upsampling stage for the CNN pipeline, operating on a streamed multi-channel feature map. It captures one full frame of CHANNEL_NUM x IMAGE_HEIGHT x IMAGE_WIDTH pixels into an internal buffer. It then streams out a 2*IMAGE_HEIGHT x 2*IMAGE_WIDTH map per channel, in which every input pixel is replicated into a 2x2 block. Pixels are opaque DATA_WIDTH words: no arithmetic, and values pass through unchanged.

Parameters:
DATA_WIDTH, 32, pixel word width
IMAGE_WIDTH, 16, input columns per channel
IMAGE_HEIGHT, 16, input rows per channel
CHANNEL_NUM, 4, number of channels per frame

Ports:
clk  input  1  clock, all logic on rising edge
reset  input  1  synchronous, active-low reset
valid_in  input  1  pxl_in carries a valid input pixel this cycle
pxl_in  input  DATA_WIDTH  input pixel; order is channel-major, then row-major (row 0 col 0 first)
pxl_out  output  DATA_WIDTH  upsampled output pixel, registered
valid_out  output  1  pxl_out valid this cycle, registered

Behaviour:
- Sizes:
  - N_IN = CHANNEL_NUM*IMAGE_WIDTH*IMAGE_HEIGHT (default 1024).
  - OW = 2*IMAGE_WIDTH, OH = 2*IMAGE_HEIGHT.
  - N_OUT = 4*N_IN (default 4096).
- Reset (reset=0 at a rising edge):
  - valid_out=0, pxl_out=0.
  - Write counter and all output counters go to 0; state=LOAD.
  - Buffer contents are don't-care.
  - Reset mid-LOAD or mid-OUT aborts the frame immediately.
- Buffer: N_IN x DATA_WIDTH memory with a synchronous read port. Write address is the linear input index.
- State LOAD:
  - Each cycle with valid_in=1: write pxl_in at wr_addr, then wr_addr++.
  - valid_in=0 stalls the write counter; gaps of any length are allowed.
  - On the edge that writes index N_IN-1: wr_addr returns to 0 and state becomes OUT.
  - valid_out stays 0 in LOAD.
- State OUT:
  - Output counters c (channel), y (0..OH-1), x (0..OW-1); x is the fastest.
  - Read address = c*IMAGE_SIZE + (y>>1)*IMAGE_WIDTH + (x>>1).
  - One read is issued per cycle with no gaps.
  - pxl_out/valid_out are registered from the read data, giving a 1-cycle read latency.
  - Consequence: the first valid_out=1 occurs at the 2nd rising edge after the edge that captured the last input pixel.
  - valid_out is then high for exactly N_OUT consecutive cycles.
  - Output order is channel-major, row-major over the OH x OW map, with out(c,y,x)=in(c,y/2,x/2).
- Counter wrap:
  - x wraps at OW-1 and increments y.
  - y wraps at OH-1 and increments c.
  - After issuing c=CHANNEL_NUM-1, y=OH-1, x=OW-1: state returns to LOAD and counters clear.
  - valid_out drops to 0 in the cycle after the last output pixel.
- Input during OUT: valid_in/pxl_in are ignored and dropped. Upstream must not send the next frame until valid_out has fallen.
- Back-to-back frames: after returning to LOAD, the next frame is accepted normally with no extra idle cycles.
- While valid_out=0, pxl_out holds its last value. It is 0 after reset.
- X/undefined pxl_in is stored as-is. No checking is performed.

Test Plan:
- Reset: hold reset=0 for 2 cycles, then release. Required: valid_out=0, pxl_out=0, and valid_out stays 0 while no input arrives.
- Ramp frame: feed 1024 contiguous pixels with value = index (0x00000000..0x000003FF).
  - First valid_out occurs 2 edges after the last input.
  - Exactly 4096 valid outputs in a row.
  - Outputs 0..3 = 0,0,1,1. Outputs 32..35 = 0,0,1,1. Output 64 = 0x10.
  - Output 1024 = 0x100 (channel 1 start). Output 4095 = 0x3FF.
- Stalled input: the same frame with valid_in deasserted for 3 cycles every 7 pixels. Required: output sequence identical to the ramp case; no output before the last input.
- Input during OUT: after the ramp frame, drive valid_in=1 with 0xDEADBEEF throughout OUT. Required: no 0xDEADBEEF appears at the output; the block returns to LOAD after 4096 outputs.
- Two frames: ramp frame, then a second frame with value = 0xA0000000+index, sent after valid_out falls. Required: the second output burst reproduces the mapping with the new values, e.g. output 1 = 0xA0000000 and output 2 = 0xA0000001.
- Reset mid-OUT: assert reset after 100 outputs. Required: valid_out=0 on the next cycle. A fresh full frame afterwards produces a correct 4096-pixel burst.
